// File: rtl/audio_preprocessor_mc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel audio pre-processor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the filter mode enum, the control FSM state enum, the per-mode
// coefficient function and the width helpers used by the MAC datapath.
package audio_pre_pkg;

    typedef enum logic [1:0] {
        BASS   = 2'd0,
        TREBLE = 2'd1,
        VOICE  = 2'd2,
        BYPASS = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int COEF_W_DEF = 16;

    // Accumulator must hold TAPS full-width products without overflow.
    function automatic int acc_width(int data_w, int coef_w, int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Coefficients are Q1.(COEF_W-1), so dropping COEF_W-1 bits returns to sample scale.
    function automatic int round_shift(int coef_w);
        return coef_w - 1;
    endfunction

    // Adding half an output LSB before the arithmetic shift gives round-half-up.
    function automatic int round_half(int coef_w);
        return 1 << (coef_w - 2);
    endfunction

    // h[tap] for the selected mode; 0.5 in Q1.15 is 16384.
    function automatic int coef(mode_e mode, int tap, int taps, int coef_w);
        int h;
        h = 0;
        case (mode)
            BASS:    h = (1 << (coef_w - 1)) / taps;
            TREBLE:  h = (tap == 0) ?  (1 << (coef_w - 2)) :
                         (tap == 1) ? -(1 << (coef_w - 2)) : 0;
            VOICE:   h = (tap == 0) ?  (1 << (coef_w - 2)) :
                         (tap == 2) ? -(1 << (coef_w - 2)) : 0;
            default: h = 0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/audio_preprocessor_mc_if.sv
// Sample-in / result-out handshake bundle of the audio pre-processor.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the source, out_ready throttles the block.
//
// master = source/sink side, slave = the pre-processor itself.
interface audio_preprocessor_mc_if #(
    parameter int DATA_W = 16,
    parameter int CHAN_W = 1
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHAN_W-1:0] out_chan;
    logic              out_clip;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_clip
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_clip
    );
endinterface

// File: rtl/audio_preprocessor_mc_mac.sv
// Serial signed MAC with clear, accumulate and round/saturate result register.
// Latency: result registered on the edge that accumulates the last tap.
// Backpressure: none; result/clip hold until the next 'last' cycle.
//
// Ports: clk, rst (sync, active-high), clear, acc_en, last, pass/pass_data
// (bypass path), x/h (sample and coefficient for this tap), res, clip.
module audio_mac
    import audio_pre_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic                     last,
    input  logic                     pass,
    input  logic signed [DATA_W-1:0] pass_data,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [COEF_W-1:0] h,
    output logic signed [DATA_W-1:0] res,
    output logic                     clip
);
    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int RSH   = round_shift(COEF_W);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(round_half(COEF_W));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2**(DATA_W-1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         acc;
    logic signed [ACC_W-1:0]         sum;
    logic signed [ACC_W:0]           rnd;
    logic signed [ACC_W:0]           shifted;

    // One extra bit on the rounding path so adding HALF can never wrap.
    always_comb begin
        prod    = x * h;
        sum     = acc + ACC_W'(prod);
        rnd     = (ACC_W+1)'(sum) + HALF;
        shifted = rnd >>> RSH;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            res  <= '0;
            clip <= 1'b0;
        end else if (clear) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= sum;
            if (last) begin
                if (pass) begin
                    res  <= pass_data;
                    clip <= 1'b0;
                end else if (shifted > SAT_MAX) begin
                    res  <= SAT_MAX[DATA_W-1:0];
                    clip <= 1'b1;
                end else if (shifted < SAT_MIN) begin
                    res  <= SAT_MIN[DATA_W-1:0];
                    clip <= 1'b1;
                end else begin
                    res  <= shifted[DATA_W-1:0];
                    clip <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/audio_preprocessor_mc.sv
// Multi-channel FIR pre-processor: per-channel delay lines, 4 modes, serial MAC.
// Latency: out_valid after LOAD + TAPS MAC cycles; one sample per TAPS+3 cycles.
// Backpressure: one sample in flight; in_ready only in IDLE, OUT holds until out_ready.
//
// Ports: clk, rst (sync, active-high), filter_sel (mode, latched at channel 0),
// bus (slave: in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_chan/out_clip).
module audio_preprocessor_mc
    import audio_pre_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int CHANNELS = 2,
    parameter int TAPS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] filter_sel,
    audio_preprocessor_mc_if.slave bus
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TAP_W  = $clog2(TAPS);

    state_e                    state;
    mode_e                     mode_q;
    logic [CHAN_W-1:0]         chan_cnt;
    logic [CHAN_W-1:0]         cur_chan;
    logic [CHAN_W-1:0]         out_chan_q;
    logic [TAP_W-1:0]          tap_cnt;
    logic signed [DATA_W-1:0]  sample_q;
    logic signed [DATA_W-1:0]  dl [CHANNELS][TAPS];
    logic                      out_valid_q;

    logic                      accept;
    logic                      mac_clear;
    logic                      mac_en;
    logic                      mac_last;
    logic signed [COEF_W-1:0]  h_cur;
    logic signed [DATA_W-1:0]  x_cur;
    logic signed [DATA_W-1:0]  mac_res;
    logic                      mac_clip;

    // Gated by rst so the source sees not-ready for the whole reset pulse,
    // yet ready in the very first cycle after it.
    assign bus.in_ready  = (state == S_IDLE) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = mac_res;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_clip  = mac_clip;

    always_comb begin
        mac_clear = (state == S_LOAD);
        mac_en    = (state == S_MAC);
        mac_last  = mac_en && (tap_cnt == TAP_W'(TAPS - 1));
        h_cur     = COEF_W'(coef(mode_q, int'(tap_cnt), TAPS, COEF_W));
        x_cur     = dl[cur_chan][tap_cnt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mode_q      <= BASS;
            chan_cnt    <= '0;
            cur_chan    <= '0;
            out_chan_q  <= '0;
            tap_cnt     <= '0;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    dl[c][k] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sample_q <= bus.in_data;
                        cur_chan <= chan_cnt;
                        // Mode is frame-wide: only channel 0 may change it.
                        if (chan_cnt == '0) begin
                            mode_q <= mode_e'(filter_sel);
                        end
                        if (chan_cnt == CHAN_W'(CHANNELS - 1)) begin
                            chan_cnt <= '0;
                        end else begin
                            chan_cnt <= chan_cnt + 1'b1;
                        end
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        dl[cur_chan][k] <= dl[cur_chan][k-1];
                    end
                    dl[cur_chan][0] <= sample_q;
                    tap_cnt         <= '0;
                    state           <= S_MAC;
                end
                S_MAC: begin
                    if (mac_last) begin
                        out_chan_q  <= cur_chan;
                        out_valid_q <= 1'b1;
                        state       <= S_OUT;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Bypass still runs the full MAC sequence so latency is mode-independent.
    audio_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clear     (mac_clear),
        .acc_en    (mac_en),
        .last      (mac_last),
        .pass      (mode_q == BYPASS),
        .pass_data (dl[cur_chan][0]),
        .x         (x_cur),
        .h         (h_cur),
        .res       (mac_res),
        .clip      (mac_clip)
    );

endmodule
